// File: rtl/mxn_serial_shifter_pkg.sv
// Shared definitions for the bit-serial packed shifter: FSM states,
// shift-type and direction encodings.
package mxn_serial_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int OP_LOGICAL = 0;
    localparam int OP_ARITH   = 1;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/mxn_serial_shifter_lane.sv
// One WIDTH-bit lane of the serial shifter: loadable register that moves
// one bit per enabled cycle, with zero or sign fill on right shifts.
// Optional feature macro: SHIFT_CARRY_EN adds a registered carry_out bit
// holding the last bit shifted out of the lane.
module serial_shift_lane
    import mxn_serial_shifter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OP    = OP_LOGICAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             dir,
`ifdef SHIFT_CARRY_EN
    output logic             carry_out,
`endif
    output logic [WIDTH-1:0] data
);

    logic fill_bit;
    logic tap_bit;

    // Fill bit for right shifts and the bit leaving the lane this cycle
    always_comb begin
        fill_bit = 1'b0;
        if (OP == OP_ARITH) begin
            fill_bit = data[WIDTH-1];
        end
        tap_bit = (dir == DIR_RIGHT) ? data[0] : data[WIDTH-1];
    end

    // Lane register: load a fresh operand or move one position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_en) begin
            if (dir == DIR_RIGHT) begin
                data <= {fill_bit, data[WIDTH-1:1]};
            end else begin
                data <= {data[WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef SHIFT_CARRY_EN
    // Carry tap: cleared with each new operand, then tracks the last bit out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_out <= 1'b0;
        end else if (load) begin
            carry_out <= 1'b0;
        end else if (shift_en) begin
            carry_out <= tap_bit;
        end
    end
`else
    logic unused_tap;
    assign unused_tap = tap_bit;
`endif

endmodule

// File: rtl/mxn_serial_shifter.sv
// Bit-serial packed shifter: SETS independent WIDTH-bit lanes shifted one
// position per clock, with valid/ready handshakes on request and result.
// Optional feature macro: SHIFT_CARRY_EN adds the shift_out port carrying
// the last bit shifted out of each lane.
module mxn_serial_shifter
    import mxn_serial_shifter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SETS  = 2,
    parameter int OP    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SETS*WIDTH-1:0] in_packed,
    input  logic                  shift_dir,
    input  logic [WIDTH-1:0]      shift_amt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SETS*WIDTH-1:0] out_packed,
`ifdef SHIFT_CARRY_EN
    output logic [SETS-1:0]       shift_out,
`endif
    output logic                  busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] AMT_MAX = WIDTH[WIDTH-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    if (OP != OP_LOGICAL && OP != OP_ARITH) begin : g_bad_op
        $error("mxn_serial_shifter: OP must be 0 (logical) or 1 (arithmetic)");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("mxn_serial_shifter: WIDTH must be at least 2");
    end
    if (SETS < 1) begin : g_bad_sets
        $error("mxn_serial_shifter: SETS must be at least 1");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_cnt;
    logic             dir_q;
    logic             accept;
    logic             shift_en;

    assign accept   = in_valid && (state == IDLE);
    assign shift_en = (state == SHIFT) && (cnt != '0);

    // Saturate the requested amount at WIDTH so the counter stays small
    always_comb begin
        load_cnt = CNT_W'(shift_amt);
        if (shift_amt >= AMT_MAX) begin
            load_cnt = CNT_MAX;
        end
    end

    // State register, shift counter and latched direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dir_q <= DIR_LEFT;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt   <= load_cnt;
                dir_q <= shift_dir;
            end else if (shift_en) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next state and handshake outputs; a zero amount still passes through
    // SHIFT for one cycle so latency is uniformly cnt+1 after acceptance
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    for (genvar g = 0; g < SETS; g++) begin : g_lane
        serial_shift_lane #(
            .WIDTH (WIDTH),
            .OP    (OP)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (accept),
            .load_data (in_packed[g*WIDTH +: WIDTH]),
            .shift_en  (shift_en),
            .dir       (dir_q),
`ifdef SHIFT_CARRY_EN
            .carry_out (shift_out[g]),
`endif
            .data      (out_packed[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_mxn_serial_shifter.sv
// Directed testbench for mxn_serial_shifter (WIDTH=4, SETS=2). Two copies of
// the block, one logical (OP=0) and one arithmetic (OP=1), receive the same
// requests so every vector checks both shift types.
// Optional feature macro: SHIFT_CARRY_EN enables shift_out checks.
module tb_mxn_serial_shifter;

    localparam int WIDTH = 4;
    localparam int SETS  = 2;
    localparam int PW    = WIDTH * SETS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [PW-1:0] in_packed;
    logic          shift_dir;
    logic [WIDTH-1:0] shift_amt;
    logic          out_ready;

    logic          in_ready_l, in_ready_a;
    logic          out_valid_l, out_valid_a;
    logic [PW-1:0] out_packed_l, out_packed_a;
    logic          busy_l, busy_a;
`ifdef SHIFT_CARRY_EN
    logic [SETS-1:0] shift_out_l, shift_out_a;
`endif

    int vec_count = 0;
    int miscompare_count = 0;

    always #5 clk = ~clk;

    mxn_serial_shifter #(.WIDTH(WIDTH), .SETS(SETS), .OP(0)) dut_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready_l),
        .in_packed  (in_packed),
        .shift_dir  (shift_dir),
        .shift_amt  (shift_amt),
        .out_valid  (out_valid_l),
        .out_ready  (out_ready),
        .out_packed (out_packed_l),
`ifdef SHIFT_CARRY_EN
        .shift_out  (shift_out_l),
`endif
        .busy       (busy_l)
    );

    mxn_serial_shifter #(.WIDTH(WIDTH), .SETS(SETS), .OP(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .in_packed  (in_packed),
        .shift_dir  (shift_dir),
        .shift_amt  (shift_amt),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_packed (out_packed_a),
`ifdef SHIFT_CARRY_EN
        .shift_out  (shift_out_a),
`endif
        .busy       (busy_a)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        assert (observed === expected) else begin
            miscompare_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge with both blocks idle; returns the number of
    // rising edges from acceptance until out_valid is seen
    task automatic applyStimulus(input logic [PW-1:0] data, input logic dir,
                                 input logic [WIDTH-1:0] amt, output int latency);
        in_packed = data;
        shift_dir = dir;
        shift_amt = amt;
        in_valid  = 1'b1;
        checkOutput("in_ready_before_accept", 32'(in_ready_l & in_ready_a), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        latency = 0;
        while (!out_valid_l && latency < 20) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic checkResult(input string tag, input int latency,
                               input logic [PW-1:0] exp_l, input logic [PW-1:0] exp_a,
                               input int exp_lat, input logic [SETS-1:0] exp_carry);
        checkOutput({tag, "_latency"}, 32'(latency), 32'(exp_lat));
        checkOutput({tag, "_out_valid_arith"}, 32'(out_valid_a), 32'd1);
        checkOutput({tag, "_packed_logical"}, 32'(out_packed_l), 32'(exp_l));
        checkOutput({tag, "_packed_arith"}, 32'(out_packed_a), 32'(exp_a));
        checkOutput({tag, "_busy_in_done"}, 32'(busy_l), 32'd1);
        checkOutput({tag, "_in_ready_in_done"}, 32'(in_ready_l), 32'd0);
`ifdef SHIFT_CARRY_EN
        checkOutput({tag, "_carry_logical"}, 32'(shift_out_l), 32'(exp_carry));
        checkOutput({tag, "_carry_arith"}, 32'(shift_out_a), 32'(exp_carry));
`else
        if (exp_carry === 'x) $display("[TB] carry expectation unknown");
`endif
    endtask

    task automatic drainResult(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_in_ready_after_drain"}, 32'(in_ready_l & in_ready_a), 32'd1);
        checkOutput({tag, "_out_valid_after_drain"}, 32'(out_valid_l | out_valid_a), 32'd0);
        checkOutput({tag, "_busy_after_drain"}, 32'(busy_l | busy_a), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic [PW-1:0] hold_l;
        logic [PW-1:0] hold_a;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_packed = '0;
        shift_dir = 1'b0;
        shift_amt = '0;
        out_ready = 1'b0;

        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready_l & in_ready_a), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid_l | out_valid_a), 32'd0);
        checkOutput("reset_busy", 32'(busy_l | busy_a), 32'd0);
        checkOutput("reset_packed_logical", 32'(out_packed_l), 32'h00);
        checkOutput("reset_packed_arith", 32'(out_packed_a), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] left shift by 1");
        applyStimulus(8'h81, 1'b0, 4'd1, lat);
        checkResult("left1", lat, 8'h02, 8'h02, 2, 2'b10);
        drainResult("left1");

        $display("[TB] right shift by 1");
        applyStimulus(8'h81, 1'b1, 4'd1, lat);
        checkResult("right1", lat, 8'h40, 8'hC0, 2, 2'b01);
        drainResult("right1");

        $display("[TB] zero amount");
        applyStimulus(8'h81, 1'b1, 4'd0, lat);
        checkResult("zero", lat, 8'h81, 8'h81, 1, 2'b00);
        drainResult("zero");

        $display("[TB] saturating right shift");
        applyStimulus(8'h81, 1'b1, 4'd7, lat);
        checkResult("sat_right7", lat, 8'h00, 8'hF0, 5, 2'b10);
        drainResult("sat_right7");

        $display("[TB] saturating right shift, negative low lane");
        applyStimulus(8'h3C, 1'b1, 4'd15, lat);
        checkResult("sat_right15", lat, 8'h00, 8'h0F, 5, 2'b01);
        drainResult("sat_right15");

        $display("[TB] left shift by exactly WIDTH");
        applyStimulus(8'h7E, 1'b0, 4'd4, lat);
        checkResult("left4", lat, 8'h00, 8'h00, 5, 2'b10);
        drainResult("left4");

        $display("[TB] left shift by 2");
        applyStimulus(8'hA5, 1'b0, 4'd2, lat);
        checkResult("left2", lat, 8'h84, 8'h84, 3, 2'b01);
        drainResult("left2");

        $display("[TB] right shift by 2 then backpressure");
        applyStimulus(8'hA5, 1'b1, 4'd2, lat);
        checkResult("right2", lat, 8'h21, 8'hE1, 3, 2'b10);
        hold_l = out_packed_l;
        hold_a = out_packed_a;
        in_packed = 8'hFF;
        shift_dir = 1'b0;
        shift_amt = 4'd1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_logical", 32'(out_packed_l), 32'h21);
            checkOutput("bp_hold_arith", 32'(out_packed_a), 32'hE1);
            checkOutput("bp_stable", 32'(out_packed_l ^ hold_l | out_packed_a ^ hold_a), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready_l | in_ready_a), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid_l & out_valid_a), 32'd1);
        end
        in_valid = 1'b0;
        drainResult("bp");

        $display("[TB] reset during SHIFT");
        in_packed = 8'hFF;
        shift_dir = 1'b1;
        shift_amt = 4'd4;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midshift_busy", 32'(busy_l & busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midshift_rst_in_ready", 32'(in_ready_l & in_ready_a), 32'd1);
        checkOutput("midshift_rst_out_valid", 32'(out_valid_l | out_valid_a), 32'd0);
        checkOutput("midshift_rst_busy", 32'(busy_l | busy_a), 32'd0);
        checkOutput("midshift_rst_packed_logical", 32'(out_packed_l), 32'h00);
        checkOutput("midshift_rst_packed_arith", 32'(out_packed_a), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(8'h81, 1'b1, 4'd1, lat);
        checkResult("after_reset", lat, 8'h40, 8'hC0, 2, 2'b01);
        drainResult("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
